rr_pipe_arbiter: RTL and testbench
==================================

Name: rr_pipe_arbiter

Overview:
- Shares one downstream valid/data/enable pipe between N_REQ upstream requesters.
- Packet-aware round-robin: a requester keeps the grant until it sends its last beat or hits the burst cap.
- Has a one-entry registered output stage, so valid and data timing paths are broken.
- The enable path is combinational from e_down to e_up, matching the team's pipe-stage handshake.

Parameters:
N_REQ, 4, number of requesters (2..16)
DW, 32, data width per requester
MAX_BURST, 8, maximum beats per grant before forced release (>=1)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
v_up  in  N_REQ  per-requester valid
d_up  in  N_REQ*DW  per-requester data; requester i occupies bits [i*DW +: DW]
l_up  in  N_REQ  per-requester last-beat flag, qualified by v_up
e_up  out  N_REQ  per-requester enable; beat i transfers when v_up[i]&e_up[i]
v_down  out  1  valid to downstream
d_down  out  DW  data to downstream
l_down  out  1  last flag to downstream
gnt_id  out  clog2(N_REQ)  requester index of the beat in d_down
e_down  in  1  enable from downstream
busy  out  1  high while a multi-beat grant is locked

Behaviour:
- Definitions:
  - accept = e_down | ~v_down: the output register can load this cycle.
  - xfer = a beat moves upstream to stage, i.e. v_up[g] & e_up[g].
- Reset (rst=1 at posedge):
  - Outputs: v_down=0, l_down=0, d_down=0, gnt_id=0, busy=0.
  - Internal: state=IDLE, rr pointer ptr=0, beat count cnt=0.
  - Takes priority over every other event, including mid-burst. A partially sent packet is abandoned; the requester must resend it.
- States: IDLE, LOCKED.
- IDLE:
  - winner g = first i with v_up[i]=1, searching ptr, ptr+1, ... modulo N_REQ.
  - e_up[g] = accept; all other e_up = 0. If no v_up is set, all e_up = 0.
  - On xfer with l_up[g]=1, or MAX_BURST=1: stay IDLE, ptr <= g+1 mod N_REQ, cnt <= 0.
  - On xfer with l_up[g]=0 and MAX_BURST>1: go to LOCKED, owner <= g, cnt <= 1.
  - No xfer: no state, pointer or count change.
- LOCKED:
  - e_up[owner] = accept; all others 0.
  - Owner dropping v_up does NOT release the grant; bubbles are allowed and other requesters wait.
  - On xfer: cnt <= cnt+1.
  - Release when xfer and (l_up[owner]=1 or cnt+1 == MAX_BURST): go to IDLE, ptr <= owner+1 mod N_REQ, cnt <= 0.
  - A forced release does NOT alter l_down; l_down always equals the forwarded l_up.
- Output stage:
  - When accept: v_down <= xfer, and gnt_id <= g (or owner in LOCKED).
  - When xfer also: d_down <= selected d_up, l_down <= selected l_up.
  - When accept is low: all output registers hold.
  - Data and l registers load only on xfer; with v_down=0 their contents are don't-care but must hold stable.
- Latency: exactly 1 cycle from xfer to v_down=1. Full throughput of one beat per cycle while e_down=1.
- busy = (state == LOCKED), registered.
- Fairness: ptr moves only on grant release. Any continuously requesting requester is served within N_REQ-1 grants.
- Downstream backpressure (e_down=0 with v_down=1): all e_up = 0 and outputs hold stable.

Test Plan:
- Reset mid-burst:
  - Stimulus: req1 sends 3 of 5 beats, then rst=1 for 1 cycle.
  - Required: next cycle v_down=0, busy=0, ptr=0. A pending req0 and req1 then result in req0 granted first.
- Round-robin single beats:
  - Stimulus: N_REQ=4, e_down=1, all v_up=1 with l_up=1, d_up[i]=32'hA0+i.
  - Required: d_down sequence A0,A1,A2,A3,A0 on consecutive cycles; gnt_id 0,1,2,3,0; busy stays 0.
- Packet lock:
  - Stimulus: req2 sends 4 beats (l_up on beat 4) while req0 requests.
  - Required: d_down shows 4 req2 beats back-to-back with gnt_id=2, then req0's beat. busy=1 from after beat 1 through beat 4.
- Burst cap:
  - Stimulus: MAX_BURST=8; req1 streams 10 beats with l_up=0 throughout, while req3 also requests.
  - Required: after 8 req1 beats, grant passes to req3 with l_down=0 on beat 8; req1 resumes later.
- Backpressure:
  - Stimulus: v_down=1 holding D=32'h55, e_down=0 for 3 cycles, req0 valid.
  - Required: e_up=0, d_down=55 and v_down=1 stable for 3 cycles. Once e_down=1, req0's beat appears on the following cycle.
- Owner bubble:
  - Stimulus: in LOCKED with owner=0, v_up[0] goes 0 for 2 cycles while v_up[1]=1.
  - Required: e_up[1]=0 throughout, v_down=0 for the bubble, then req0 continues.

Source files
------------

// File: rtl/rr_pipe_arbiter.sv
// Packet-aware round-robin arbiter: N_REQ upstream valid/data/enable pipes
// share one downstream pipe through a single registered output stage.
module rr_pipe_arbiter #(
  parameter int N_REQ     = 4,
  parameter int DW        = 32,
  parameter int MAX_BURST = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           v_up,
  input  logic [N_REQ*DW-1:0]        d_up,
  input  logic [N_REQ-1:0]           l_up,
  output logic [N_REQ-1:0]           e_up,
  output logic                       v_down,
  output logic [DW-1:0]              d_down,
  output logic                       l_down,
  output logic [$clog2(N_REQ)-1:0]   gnt_id,
  input  logic                       e_down,
  output logic                       busy
);

  localparam int IW = $clog2(N_REQ);
  localparam int CW = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t          state;
  logic [IW-1:0]   ptr;
  logic [IW-1:0]   owner;
  logic [CW-1:0]   cnt;

  logic [DW-1:0]   d_arr [N_REQ];
  logic [IW-1:0]   idx;
  logic [IW-1:0]   win;
  logic            found;
  logic [IW-1:0]   sel;
  logic            sel_v;
  logic            sel_l;
  logic [DW-1:0]   sel_d;
  logic            accept;
  logic            xfer;
  logic [CW-1:0]   cnt_inc;
  logic            rel;

  function automatic logic [IW-1:0] inc_wrap(input logic [IW-1:0] i);
    return (int'(i) == N_REQ - 1) ? '0 : i + 1'b1;
  endfunction

  for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
    assign d_arr[i] = d_up[i*DW +: DW];
  end

  // Stage p0: requester selection and upstream enable
  always_comb begin
    idx   = '0;
    win   = '0;
    found = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = IW'((int'(ptr) + k) % N_REQ);
      if (!found && v_up[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end

    sel     = (state == LOCKED) ? owner : win;
    sel_v   = (state == LOCKED) ? v_up[owner] : found;
    sel_l   = l_up[sel];
    sel_d   = d_arr[sel];
    accept  = e_down | ~v_down;
    xfer    = sel_v & accept;
    cnt_inc = cnt + 1'b1;
    // cnt is 0 in IDLE, so the cap test also covers MAX_BURST == 1
    rel     = sel_l | (cnt_inc == CW'(MAX_BURST));

    e_up = '0;
    if (state == LOCKED || found) e_up[sel] = accept;
  end

  // Stage p1: grant state and registered output
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      ptr    <= '0;
      owner  <= '0;
      cnt    <= '0;
      v_down <= 1'b0;
      l_down <= 1'b0;
      d_down <= '0;
      gnt_id <= '0;
    end else begin
      if (xfer) begin
        if (rel) begin
          state <= IDLE;
          ptr   <= inc_wrap(sel);
          cnt   <= '0;
        end else begin
          state <= LOCKED;
          owner <= sel;
          cnt   <= cnt_inc;
        end
      end
      if (accept) begin
        v_down <= xfer;
        gnt_id <= sel;
      end
      if (xfer) begin
        d_down <= sel_d;
        l_down <= sel_l;
      end
    end
  end

  assign busy = (state == LOCKED);

endmodule

// File: tb/tb_rr_pipe_arbiter.sv
// Directed bench for rr_pipe_arbiter (N_REQ=4, DW=32, MAX_BURST=8).
module tb_rr_pipe_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   v_up;
  logic [127:0] d_up;
  logic [3:0]   l_up;
  logic [3:0]   e_up;
  logic         v_down;
  logic [31:0]  d_down;
  logic         l_down;
  logic [1:0]   gnt_id;
  logic         e_down;
  logic         busy;

  int ntests = 0;
  int nfail  = 0;

  rr_pipe_arbiter #(.N_REQ(4), .DW(32), .MAX_BURST(8)) dut (
    .clk    (clk),
    .rst    (rst),
    .v_up   (v_up),
    .d_up   (d_up),
    .l_up   (l_up),
    .e_up   (e_up),
    .v_down (v_down),
    .d_down (d_down),
    .l_down (l_down),
    .gnt_id (gnt_id),
    .e_down (e_down),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic setd(input int i, input logic [31:0] v);
    d_up[i*32 +: 32] = v;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_beat(input string tag, input logic [31:0] d, input logic [1:0] g,
                          input logic l, input logic b);
    chk({tag, ".v"},    64'(v_down), 64'(1));
    chk({tag, ".d"},    64'(d_down), 64'(d));
    chk({tag, ".gnt"},  64'(gnt_id), 64'(g));
    chk({tag, ".l"},    64'(l_down), 64'(l));
    chk({tag, ".busy"}, 64'(busy),   64'(b));
  endtask

  initial begin
    rst = 1'b1; v_up = '0; l_up = '0; d_up = '0; e_down = 1'b1;
    tick(); tick();
    chk("rst.v",    64'(v_down), 64'(0));
    chk("rst.l",    64'(l_down), 64'(0));
    chk("rst.d",    64'(d_down), 64'(0));
    chk("rst.gnt",  64'(gnt_id), 64'(0));
    chk("rst.busy", 64'(busy),   64'(0));

    // Round-robin single beats
    rst = 1'b0; v_up = 4'hF; l_up = 4'hF;
    for (int i = 0; i < 4; i++) setd(i, 32'hA0 + 32'(i));
    #1 chk("rr.e_up", 64'(e_up), 64'(4'b0001));
    for (int k = 0; k < 5; k++) begin
      tick();
      chk_beat("rr", 32'hA0 + 32'(k % 4), 2'(k % 4), 1'b1, 1'b0);
    end

    // Packet lock: req2 four beats, req0 waiting (ptr=1)
    v_up = 4'b0101; l_up = 4'b0001; setd(0, 32'h100);
    for (int b = 0; b < 4; b++) begin
      setd(2, 32'h200 + 32'(b));
      l_up[2] = (b == 3);
      #1 chk("lock.e_up", 64'(e_up), 64'(4'b0100));
      tick();
      chk_beat("lock", 32'h200 + 32'(b), 2'd2, b == 3, b != 3);
    end
    v_up = 4'b0001;
    #1 chk("lock.e_up0", 64'(e_up), 64'(4'b0001));
    tick();
    chk_beat("lock.req0", 32'h100, 2'd0, 1'b1, 1'b0);

    // Burst cap: req1 streams without last, req3 waiting (ptr=1)
    v_up = 4'b1010; l_up = 4'b1000; setd(3, 32'h3F3);
    for (int b = 0; b < 8; b++) begin
      setd(1, 32'h300 + 32'(b));
      tick();
      chk_beat("cap", 32'h300 + 32'(b), 2'd1, 1'b0, b != 7);
    end
    setd(1, 32'h308);
    #1 chk("cap.e_up3", 64'(e_up), 64'(4'b1000));
    tick();
    chk_beat("cap.req3", 32'h3F3, 2'd3, 1'b1, 1'b0);
    v_up = 4'b0010;
    tick();
    chk_beat("cap.resume9", 32'h308, 2'd1, 1'b0, 1'b1);
    setd(1, 32'h309); l_up[1] = 1'b1;
    tick();
    chk_beat("cap.resume10", 32'h309, 2'd1, 1'b1, 1'b0);

    // Backpressure (ptr=2, req0 is the only requester)
    v_up = 4'b0001; l_up = 4'b0001; setd(0, 32'h55);
    tick();
    chk_beat("bp.load", 32'h55, 2'd0, 1'b1, 1'b0);
    e_down = 1'b0; setd(0, 32'h66);
    for (int c = 0; c < 3; c++) begin
      #1 chk("bp.e_up", 64'(e_up), 64'(0));
      tick();
      chk_beat("bp.hold", 32'h55, 2'd0, 1'b1, 1'b0);
    end
    e_down = 1'b1;
    #1 chk("bp.e_up_rel", 64'(e_up), 64'(4'b0001));
    tick();
    chk_beat("bp.next", 32'h66, 2'd0, 1'b1, 1'b0);
    v_up = '0;
    tick();
    chk("bp.idle.v", 64'(v_down), 64'(0));

    // Owner bubble (ptr=1): req0 locks, then drops valid for two cycles
    v_up = 4'b0001; l_up = 4'b0000; setd(0, 32'h700); setd(1, 32'h711);
    tick();
    chk_beat("bub.b1", 32'h700, 2'd0, 1'b0, 1'b1);
    v_up = 4'b0010; l_up = 4'b0010;
    for (int c = 0; c < 2; c++) begin
      #1 chk("bub.e_up", 64'(e_up), 64'(4'b0001));
      tick();
      chk("bub.v",    64'(v_down), 64'(0));
      chk("bub.busy", 64'(busy),   64'(1));
    end
    v_up = 4'b0011; l_up = 4'b0011; setd(0, 32'h701);
    #1 chk("bub.e_up_back", 64'(e_up), 64'(4'b0001));
    tick();
    chk_beat("bub.b2", 32'h701, 2'd0, 1'b1, 1'b0);
    v_up = '0;
    tick();

    // Reset mid-burst (ptr=1): req1 sends 3 beats of a packet, then reset
    v_up = 4'b0010; l_up = 4'b0000;
    for (int b = 0; b < 3; b++) begin
      setd(1, 32'h800 + 32'(b));
      tick();
      chk_beat("mid", 32'h800 + 32'(b), 2'd1, 1'b0, 1'b1);
    end
    rst = 1'b1; v_up = 4'b0011; l_up = 4'b0011; setd(0, 32'h900); setd(1, 32'h901);
    tick();
    chk("mid.rst.v",    64'(v_down), 64'(0));
    chk("mid.rst.busy", 64'(busy),   64'(0));
    chk("mid.rst.d",    64'(d_down), 64'(0));
    rst = 1'b0;
    #1 chk("mid.e_up", 64'(e_up), 64'(4'b0001));
    tick();
    chk_beat("mid.req0", 32'h900, 2'd0, 1'b1, 1'b0);
    tick();
    chk_beat("mid.req1", 32'h901, 2'd1, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
